// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared types and default sizing for the sequential multi-word adder.
//   addseq_state_t : controller state encoding (IDLE, RUN, DONE)
//   ADDSEQ_N       : default slice adder width
//   ADDSEQ_WORDS   : default number of slices per operation
package add_seq_pkg;

    localparam int unsigned ADDSEQ_N     = 64;
    localparam int unsigned ADDSEQ_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addseq_state_t;

endpackage : add_seq_pkg

// File: rtl/cla.sv
// cla: N-bit combinational carry-lookahead adder slice.
// Ports:
//   A, B : addends
//   Cin  : carry in
//   Sum  : A + B + Cin (low N bits)
//   Cout : carry out of bit N-1
module cla #(
    parameter int unsigned N = 64
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout
);

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;

    assign g = A & B;
    assign p = A ^ B;

    // Generate/propagate carry recurrence; the prefix structure is left to synthesis.
    always_comb begin
        c    = '0;
        c[0] = Cin;
        for (int i = 0; i < int'(N); i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign Sum  = p ^ c[N-1:0];
    assign Cout = c[N];

endmodule : cla

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: performs one N*WORDS-bit addition by running a single N-bit
// cla slice over WORDS cycles, LS word first, carry chained through a register.
// Optional feature macro: ADDSEQ_SUB_EN adds the `sub` port (A - B).
// Ports:
//   clk, rst            : clock, async active-high reset
//   in_valid / in_ready : operand handshake (a, b, cin[, sub])
//   out_valid/out_ready : result handshake (sum, cout), all outputs registered
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int unsigned N     = ADDSEQ_N,
    parameter int unsigned WORDS = ADDSEQ_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic             cin,
`ifdef ADDSEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*WORDS-1:0] sum,
    output logic             cout
);

    localparam int unsigned W    = N * WORDS;
    localparam int unsigned IW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    addseq_state_t state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic [N-1:0]  slice_a;
    logic [N-1:0]  slice_b;
    logic [N-1:0]  slice_sum;
    logic          slice_cout;
    int unsigned   base;

    // Word mux feeding the slice adder.
    assign base    = 32'(idx_q) * N;
    assign slice_a = a_q[base +: N];
    assign slice_b = b_q[base +: N];

    cla #(.N(N)) u_cla (
        .A    (slice_a),
        .B    (slice_b),
        .Cin  (carry_q),
        .Sum  (slice_sum),
        .Cout (slice_cout)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        cout_d      = cout_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = a;
                    idx_d = '0;
`ifdef ADDSEQ_SUB_EN
                    // Subtract as A + ~B + 1; cin is irrelevant then.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
`else
                    b_d     = b;
                    carry_d = cin;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[base +: N] = slice_sum;
                carry_d          = slice_cout;
                idx_d            = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    cout_d  = slice_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule : add_seq_ctrl

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: self-checking bench for add_seq_ctrl (N=64, WORDS=4).
// Honors ADDSEQ_SUB_EN to exercise the subtract port.
module tb_add_seq_ctrl;

    localparam int unsigned N     = 64;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = N * WORDS;
    localparam int unsigned WP    = W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    add_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADDSEQ_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    // Reference: whole-width arithmetic, result bit W is the carry out.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
        logic [W-1:0] ny;
        ny = ~y;
        if (s) return {1'b0, x} + {1'b0, ny} + WP'(1);
        return {1'b0, x} + {1'b0, y} + WP'(c);
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(W / 32); i++) r = {r[W-33:0], 32'($urandom)};
        return r;
    endfunction

    task automatic chk(input string name, input logic [W:0] got, input logic [W:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with out_ready held high.
    task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc, input logic vs,
                          input logic [W-1:0] exp_sum, input logic exp_cout);
        int lat;
        for (int i = 0; i < 20 && !in_ready; i++) step();
        chk({name, " in_ready"}, WP'(in_ready), WP'(1));
        a = va; b = vb; cin = vc; sub_i = vs;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        a = ~va; b = ~vb; cin = ~vc;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({name, " latency"}, WP'(lat), WP'(WORDS + 1));
        chk({name, " sum"}, {1'b0, sum}, {1'b0, exp_sum});
        chk({name, " cout"}, WP'(cout), WP'(exp_cout));
        step();
    endtask

    initial begin
        vec_t         vecs[$];
        vec_t         v;
        logic [W:0]   m;
        logic [W:0]   expq[$];
        logic [W-1:0] ra, rb;
        logic         rc, rs, acc;
        int           got, prev, cyc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub_i = 1'b0;

        // Directed table.
        v.name = "allones_plus1"; v.a = '1; v.b = W'(1); v.cin = 1'b0; v.sub = 1'b0;
        v.exp_sum = '0; v.exp_cout = 1'b1; vecs.push_back(v);
        v.name = "carry_w0_w1"; v.a = {192'd0, 64'hFFFF_FFFF_FFFF_FFFF}; v.b = W'(1);
        v.cin = 1'b0; v.sub = 1'b0; v.exp_sum = {191'd0, 1'b1, 64'd0}; v.exp_cout = 1'b0;
        vecs.push_back(v);
        v.name = "zero_cin1"; v.a = '0; v.b = '0; v.cin = 1'b1; v.sub = 1'b0;
        v.exp_sum = W'(1); v.exp_cout = 1'b0; vecs.push_back(v);
        v.name = "hi_word_ovf"; v.a = {64'h8000_0000_0000_0000, 192'd5};
        v.b = {64'h8000_0000_0000_0000, 192'd6}; v.cin = 1'b1; v.sub = 1'b0;
        v.exp_sum = W'(12); v.exp_cout = 1'b1; vecs.push_back(v);
`ifdef ADDSEQ_SUB_EN
        v.name = "sub_5_7"; v.a = W'(5); v.b = W'(7); v.cin = 1'b0; v.sub = 1'b1;
        v.exp_sum = {{(W-1){1'b1}}, 1'b0}; v.exp_cout = 1'b0; vecs.push_back(v);
        v.name = "sub_7_5"; v.a = W'(7); v.b = W'(5); v.cin = 1'b1; v.sub = 1'b1;
        v.exp_sum = W'(2); v.exp_cout = 1'b1; vecs.push_back(v);
`endif

        // Reset state.
        #12;
        chk("rst in_ready", WP'(in_ready), WP'(1));
        chk("rst out_valid", WP'(out_valid), WP'(0));
        chk("rst sum", {1'b0, sum}, '0);
        chk("rst cout", WP'(cout), WP'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   vecs[i].exp_sum, vecs[i].exp_cout);

        // Random operands against the reference model.
        for (int i = 0; i < 20; i++) begin
            ra = rand_w(); rb = rand_w(); rc = 1'($urandom);
`ifdef ADDSEQ_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            if (i == 0) rb = ~ra;
            m = model(ra, rb, rc, rs);
            run_op("rand", ra, rb, rc, rs, m[W-1:0], m[W]);
        end

        // Back-pressure: result holds, new requests ignored.
        sub_i = 1'b0;
        a = '0; b = '0; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        step();
        a = W'(5); b = W'(5); cin = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) step();
        for (int i = 0; i < 3; i++) begin
            chk("hold out_valid", WP'(out_valid), WP'(1));
            chk("hold sum", {1'b0, sum}, WP'(1));
            chk("hold cout", WP'(cout), WP'(0));
            chk("hold in_ready", WP'(in_ready), WP'(0));
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("post_hold in_ready", WP'(in_ready), WP'(1));
        chk("post_hold out_valid", WP'(out_valid), WP'(0));
        chk("post_hold sum", {1'b0, sum}, WP'(1));

        // Reset during the second RUN beat aborts the operation.
        a = '1; b = '1; cin = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("abort out_valid", WP'(out_valid), WP'(0));
        chk("abort sum", {1'b0, sum}, '0);
        chk("abort cout", WP'(cout), WP'(0));
        chk("abort in_ready", WP'(in_ready), WP'(1));
        step();
        rst = 1'b0;
        step();
        run_op("after_abort", W'(3), W'(4), 1'b0, 1'b0, W'(7), 1'b0);

        // Back-to-back streaming.
        in_valid = 1'b1; out_ready = 1'b1; sub_i = 1'b0;
        a = rand_w(); b = rand_w(); cin = 1'($urandom);
        got = 0; prev = -1; cyc = 0;
        while (got < 5 && cyc < 80) begin
            chk("b2b exclusive", WP'(in_ready & out_valid), WP'(0));
            if (out_valid) begin
                chk("b2b queue", WP'(expq.size() > 0), WP'(1));
                if (expq.size() > 0) begin
                    m = expq.pop_front();
                    chk("b2b sum", {1'b0, sum}, {1'b0, m[W-1:0]});
                    chk("b2b cout", WP'(cout), WP'(m[W]));
                end
                if (prev >= 0) chk("b2b interval", WP'(cyc - prev), WP'(WORDS + 2));
                prev = cyc;
                got++;
            end
            acc = in_ready;
            if (acc) expq.push_back(model(a, b, cin, 1'b0));
            step();
            cyc++;
            if (acc) begin
                a = rand_w(); b = rand_w(); cin = 1'($urandom);
            end
        end
        chk("b2b count", WP'(got), WP'(5));
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !in_ready; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_add_seq_ctrl

// File: doc/add_seq_ctrl.md
# add_seq_ctrl

Sequential multi-word adder controller. It performs one wide addition of `N*WORDS` bits by running a single `N`-bit slice adder over `WORDS` consecutive cycles, least-significant word first, and chaining the carry through a register. It sits between a valid/ready operand source and a valid/ready result sink, so one fast slice adder can serve arbitrarily wide operands.

## Interface
- `N`, 64: slice adder width in bits.
- `WORDS`, 4: number of slices per operation; must be ≥1.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand request.
- `in_ready` output 1: block is able to accept operands.
- `a` input `N*WORDS`: operand A.
- `b` input `N*WORDS`: operand B.
- `cin` input 1: carry-in to word 0.
- `sub` input 1: subtract request; this port exists only when `ADDSEQ_SUB_EN` is defined.
- `out_valid` output 1: result available.
- `out_ready` input 1: sink accepts the result.
- `sum` output `N*WORDS`: registered result.
- `cout` output 1: registered carry out of the top word.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid&in_ready`, capture `a`, `b`, `cin` (and `sub`), clear the word index, and go to RUN.
  - RUN: each cycle the slice adder takes word `idx` of A and B plus the carry register. The slice sum is written into word `idx` of the result register, and the slice carry is written into the carry register. `idx` increments. After beat `WORDS-1`, go to DONE.
  - DONE: `out_valid`=1. On `out_valid&out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE. Operands do not need to be held after acceptance.
- `sum` and `cout` are stable throughout DONE. They are not updated in IDLE; they hold the last result.
- The carry register is loaded with `cin` at acceptance. `cout` is the carry register after the final beat.
- Word `k` is bits `[k*N +: N]`. The index counter is `$clog2(WORDS)` bits wide, minimum 1.
- `WORDS`=1 is legal and takes one RUN beat.
- Reset at any time (including mid-RUN or DONE) forces IDLE. Reset values:
  - `in_ready`=1
  - `out_valid`=0
  - `sum`=0
  - `cout`=0
  - index=0
  - carry=0
- There is no partial-result output. An aborted operation is lost.

## Timing
- Cycle 0: request handshake.
- Cycles 1..`WORDS`: RUN beats.
- Cycle `WORDS+1`: `out_valid`=1, at the earliest.
- With `out_ready` held high: one result every `WORDS+2` cycles, and `in_ready` is high in the cycle after the output handshake.
- `in_ready` and `out_valid` are never high in the same cycle.
- `out_valid` holds until accepted, with no combinational path from `out_ready`.
- The slice adder is combinational and sits between the operand/carry registers and the result register. The register-to-register path is a single `N`-bit add.

## Configuration
- `ADDSEQ_SUB_EN` defined:
  - The `sub` port exists.
  - When `sub`=1 at acceptance, B is stored inverted and the carry register is loaded with 1, so `sum = A - B mod 2^(N*WORDS)`.
  - `cout`=1 means no borrow (A≥B unsigned).
  - `cin` is ignored when `sub`=1.
- `ADDSEQ_SUB_EN` undefined: no `sub` port and addition only. The RTL has no inversion logic.

## Structure
- Shared package `add_seq_pkg`:
  - state enum typedef `addseq_state_t` (IDLE, RUN, DONE);
  - default `N`/`WORDS` localparams.
- One sub-module: the team's `cla` carry-lookahead adder, instantiated once as `cla #(.N(N))`. Ports `A`, `B`, `Cin`, `Sum`, `Cout` are driven from the word mux and the carry register.
- All sequencing, muxing and registers live in `add_seq_ctrl`.

## Test plan
All scenarios use `N`=64, `WORDS`=4.
- All-ones A (256 bits), `b`=1, `cin`=0 → `sum`=0, `cout`=1, `out_valid` rises exactly 5 cycles after the request handshake.
- `a`=0x0000…0000_FFFF_FFFF_FFFF_FFFF, `b`=1 → `sum`=0x…0001_0000_0000_0000_0000 (carry crosses word 0→1), `cout`=0.
- `a`=`b`=0, `cin`=1 → `sum`=1, `cout`=0. Then hold `out_ready`=0 for 3 cycles → `out_valid`, `sum` and `cout` stay constant, `in_ready`=0, and a new `in_valid` is not accepted.
- Request accepted, `rst` pulsed during the second RUN beat → `out_valid`=0, `sum`=0, `in_ready`=1 after reset. The next request `a`=3, `b`=4 returns `sum`=7.
- Back-to-back with `out_ready`=1 and `in_valid`=1 continuously → one result every 6 cycles, and each result matches its own operands.
- With `ADDSEQ_SUB_EN`: `a`=5, `b`=7, `sub`=1 → `sum`=2^256−2, `cout`=0. Then `a`=7, `b`=5 → `sum`=2, `cout`=1.
